apb_uart_tx: RTL

APB completer for the UART transmit path, selected by the APB address decoder at 0x400. It accepts byte writes into a small FIFO and serialises them 8N1, LSB first, on a single `tx` line. Reads return a status word. Write wait-states are inserted while the FIFO is full, so software can stream bytes without polling.

---
 rtl/apb_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 59 +++++
 rtl/apb_uart_tx.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared constants and types for the APB UART transmitter
// Holds the decoder address, status bit positions and the TX FSM state type.
package apb_pkg;

  localparam logic [31:0] UART_TX_ADDR = 32'h0000_0400;

  localparam int STAT_FULL_BIT   = 8;
  localparam int STAT_EMPTY_BIT  = 9;
  localparam int STAT_BUSY_BIT   = 10;
  localparam int STAT_PARITY_BIT = 11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous show-ahead FIFO with registered occupancy count
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, push_data   write request and data (ignored when full)
//   pop, pop_data     read request (ignored when empty); pop_data shows the head entry
//   full, empty       derived from the registered count
//   count             occupancy, 0 to DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/apb_uart_tx.sv
// rtl/apb_uart_tx.sv - APB completer that queues bytes and sends them 8N1 on tx
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit before STOP).
// Ports:
//   pclk, presetn       clock, asynchronous active-low reset
//   psel, penable       APB select / ACCESS phase
//   pwrite, paddr       direction, address (already decoded upstream)
//   pdata, pstb         write data (byte in [7:0]) and byte strobes
//   prdata              status word on reads, zero otherwise
//   pready, perr        wait-state while FIFO full, error on write without pstb[0]
//   tx                  serial line, idle high, registered
module apb_uart_tx
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pdata,
  input  logic [3:0]            pstb,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  perr,
  output logic                  tx
);

  localparam int          CW          = $clog2(FIFO_DEPTH + 1);
  localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);

  tx_state_e         state;
  logic [15:0]       baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic              access;
  logic              wr_req;
  logic              push;
  logic              pop;
  logic              bit_end;
  logic              fifo_full;
  logic              fifo_empty;
  logic [7:0]        fifo_rdata;
  logic [CW-1:0]     fifo_count;
  logic [DATA_WIDTH-1:0] status;
`ifdef UART_TX_PARITY_EN
  logic              parity_bit;
`endif

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (pclk),
    .rst_n     (presetn),
    .push      (push),
    .push_data (pdata[7:0]),
    .pop       (pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign access  = psel & penable;
  assign wr_req  = access & pwrite & pstb[0];
  assign push    = wr_req & ~fifo_full;
  assign pready  = ~(wr_req & fifo_full);
  assign perr    = access & pwrite & ~pstb[0];
  assign bit_end = (baud_cnt == '0);

  // A new frame starts either from IDLE or straight out of the stop bit,
  // which is what keeps queued frames back-to-back.
  assign pop = ~fifo_empty & ((state == IDLE) | ((state == STOP) & bit_end));

  always_comb begin
    status                 = '0;
    status[STAT_FULL_BIT]  = fifo_full;
    status[STAT_EMPTY_BIT] = fifo_empty;
    status[STAT_BUSY_BIT]  = (state != IDLE) | ~fifo_empty;
`ifdef UART_TX_PARITY_EN
    status[STAT_PARITY_BIT] = 1'b1;
`endif
  end

  assign prdata = (access & ~pwrite) ? status : '0;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift    <= fifo_rdata;
            baud_cnt <= BAUD_RELOAD;
            tx       <= 1'b0;
            state    <= START;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^fifo_rdata;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= BAUD_RELOAD;
            bit_idx  <= '0;
            tx       <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= BAUD_RELOAD;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx    <= parity_bit;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              // Drive the next bit directly from the pre-shift value.
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            baud_cnt <= BAUD_RELOAD;
            tx       <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            if (pop) begin
              shift    <= fifo_rdata;
              baud_cnt <= BAUD_RELOAD;
              tx       <= 1'b0;
              state    <= START;
`ifdef UART_TX_PARITY_EN
              parity_bit <= ^fifo_rdata;
`endif
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{paddr, pdata[DATA_WIDTH-1:8], pstb[3:1], fifo_count};

endmodule
